// File: rtl/img_udp_pkt_tx_pkg.sv
// Shared definitions for the image-to-UDP packetiser: FSM encoding and
// frame header constants.
package img_udp_pkt_tx_pkg;

  typedef enum logic [2:0] {
    WAIT_FRAME,
    WAIT_LINE,
    START,
    SEND,
    WAIT_DONE
  } state_t;

  localparam logic [31:0] FRAME_HEAD_DEFAULT = 32'hF05A_A50F;
  localparam int unsigned HDR_BYTES          = 4;

endpackage

// File: rtl/vsync_edge_det.sv
// Two-flop rising-edge detector for an already-synchronised level signal.
// The rise pulse is registered, so it lags the input edge by one cycle.
module vsync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_d1;

  // NOTE: non-blocking assignments in clocked blocks make every flop sample
  // the pre-edge value, so sig_d1 and rise stay one stage apart.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_d1 <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sig_d1 <= sig;
      rise   <= sig & ~sig_d1;
    end
  end

endmodule

// File: rtl/img_udp_pkt_tx.sv
// Packetises camera frames for the UDP transmitter: one packet per image line,
// with a frame header word prefixed to the first line of each frame.
module img_udp_pkt_tx
  import img_udp_pkt_tx_pkg::*;
#(
  parameter int unsigned H_PIXEL    = 640,
  parameter int unsigned V_PIXEL    = 480,
  parameter logic [31:0] FRAME_HEAD = FRAME_HEAD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        transfer_flag,
  input  logic        frame_vsync,
  input  logic [11:0] fifo_rd_cnt,
  input  logic [31:0] fifo_rd_data,
  output logic        fifo_rd_en,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [31:0] tx_data,
  output logic        frame_busy
);

  localparam logic [11:0] LINE_WORDS = 12'(H_PIXEL / 2);
  localparam logic [9:0]  LAST_WORD  = 10'(H_PIXEL / 2 - 1);
  localparam logic [9:0]  LAST_LINE  = 10'(V_PIXEL - 1);
  localparam logic [15:0] LINE_BYTES = 16'(H_PIXEL * 2);

  state_t      state;
  state_t      state_nxt;
  logic        vsync_rise;
  logic        pop;
  logic        hdr_pend;
  logic        sel_fifo;
  logic [9:0]  line_cnt;
  logic [9:0]  word_cnt;
  logic [31:0] data_q;

  vsync_edge_det u_vsync_edge_det (
    .clk  (clk),
    .rst  (rst),
    .sig  (frame_vsync),
    .rise (vsync_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_FRAME;
    else     state <= state_nxt;
  end

  // NOTE: the default assignment first keeps every path assigned, so no latch
  // is inferred when a case arm leaves the state unchanged.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_FRAME: if (vsync_rise && transfer_flag)     state_nxt = WAIT_LINE;
      WAIT_LINE:  if (fifo_rd_cnt >= LINE_WORDS)      state_nxt = START;
      START:                                          state_nxt = SEND;
      SEND:       if (pop && (word_cnt == LAST_WORD)) state_nxt = WAIT_DONE;
      WAIT_DONE:  if (tx_done) state_nxt = (line_cnt == LAST_LINE) ? WAIT_FRAME : WAIT_LINE;
      default:                                        state_nxt = WAIT_FRAME;
    endcase
  end

  // The header request consumes a tx_req without touching the FIFO.
  always_comb begin
    tx_start_en = (state == START);
    pop         = (state == SEND) && tx_req && !hdr_pend && (fifo_rd_cnt != '0);
    fifo_rd_en  = pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_cnt    <= '0;
      word_cnt    <= '0;
      hdr_pend    <= 1'b0;
      frame_busy  <= 1'b0;
      tx_byte_num <= '0;
      data_q      <= '0;
      sel_fifo    <= 1'b0;
    end else begin
      sel_fifo <= pop;
      case (state)
        WAIT_FRAME: begin
          if (vsync_rise && transfer_flag) begin
            line_cnt   <= '0;
            hdr_pend   <= 1'b1;
            frame_busy <= 1'b1;
          end
        end
        WAIT_LINE: begin
          // Loaded on entry to START and held until the next line's start.
          if (fifo_rd_cnt >= LINE_WORDS)
            tx_byte_num <= LINE_BYTES + (hdr_pend ? 16'(HDR_BYTES) : 16'd0);
        end
        SEND: begin
          if (tx_req && hdr_pend) begin
            data_q   <= FRAME_HEAD;
            hdr_pend <= 1'b0;
          end
          if (pop) word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 10'd1;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            if (line_cnt == LAST_LINE) frame_busy <= 1'b0;
            else                       line_cnt   <= line_cnt + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO data arrives the cycle after the pop, so it bypasses data_q.
  assign tx_data = sel_fifo ? fifo_rd_data : data_q;

endmodule

// File: tb/tb_img_udp_pkt_tx.sv
// Bench for img_udp_pkt_tx: a FIFO model and a UDP-transmitter model drive the
// DUT; expected packets come from a frame-level model of the line/header rules.
`timescale 1ns/1ps
module tb_img_udp_pkt_tx;

  localparam int          H    = 8;
  localparam int          V    = 3;
  localparam int          LW   = H / 2;
  localparam logic [31:0] HEAD = 32'hF05A_A50F;

  typedef struct {
    bit flag;
    bit drop;
    int gap;
    bit mid_vsync;
    int exp_pkts;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        transfer_flag;
  logic        frame_vsync;
  logic [11:0] fifo_rd_cnt;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_rd_en;
  logic        tx_req;
  logic        tx_done;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic [31:0] tx_data;
  logic        frame_busy;

  logic [31:0] fmem [256];
  int          wr_ptr      = 0;
  int          rd_ptr      = 0;
  int          bad_pops    = 0;
  int          starts      = 0;
  int          busy_cycles = 0;
  logic        cnt_force   = 1'b0;
  logic [11:0] cnt_val     = '0;
  int          m_rd        = 0;
  int          checks      = 0;
  int          failures    = 0;
  vec_t        vecs [5];

  always #5 clk = ~clk;

  img_udp_pkt_tx #(.H_PIXEL(H), .V_PIXEL(V), .FRAME_HEAD(HEAD)) dut (
    .clk           (clk),
    .rst           (rst),
    .transfer_flag (transfer_flag),
    .frame_vsync   (frame_vsync),
    .fifo_rd_cnt   (fifo_rd_cnt),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_en    (fifo_rd_en),
    .tx_req        (tx_req),
    .tx_done       (tx_done),
    .tx_start_en   (tx_start_en),
    .tx_byte_num   (tx_byte_num),
    .tx_data       (tx_data),
    .frame_busy    (frame_busy)
  );

  assign fifo_rd_cnt = cnt_force ? cnt_val : 12'(wr_ptr - rd_ptr);

  // Pixel FIFO model plus event counters.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= fmem[rd_ptr % 256];
      rd_ptr       <= rd_ptr + 1;
      if (wr_ptr == rd_ptr) bad_pops <= bad_pops + 1;
    end
    if (tx_start_en) starts      <= starts + 1;
    if (frame_busy)  busy_cycles <= busy_cycles + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_words(input int n, input bit seq);
    for (int i = 0; i < n; i++) begin
      fmem[wr_ptr % 256] = seq ? {16'(2 * i + 1), 16'(2 * i + 2)} : $urandom;
      wr_ptr++;
    end
  endtask

  task automatic pulse_vsync();
    frame_vsync = 1'b1;
    tick();
    tick();
    frame_vsync = 1'b0;
    tick();
  endtask

  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (tx_start_en) seen = 1'b1;
      else             tick();
    end
  endtask

  // Transmitter side of one packet, starting in the tx_start_en cycle.
  task automatic run_packet(input bit hdr, input int gap, input bit mid_vsync);
    int          nwords;
    int          p0;
    int          idle;
    logic [31:0] exp_bytes;
    logic [31:0] exp;
    nwords    = LW + (hdr ? 1 : 0);
    exp_bytes = 32'(H * 2 + (hdr ? 4 : 0));
    check("busy_at_start", 32'(frame_busy), 32'd1);
    check("byte_num", 32'(tx_byte_num), exp_bytes);
    tick();
    p0 = rd_ptr;
    if (mid_vsync) frame_vsync = 1'b1;
    for (int w = 0; w < nwords; w++) begin
      tx_req = 1'b1;
      tick();
      tx_req = 1'b0;
      if (hdr && w == 0) exp = HEAD;
      else begin
        exp = fmem[m_rd % 256];
        m_rd++;
      end
      check($sformatf("tx_data[%0d]", w), tx_data, exp);
      idle = (gap == 0) ? 0 : (gap == 1) ? 1 : int'($urandom_range(0, 3));
      repeat (idle) tick();
    end
    frame_vsync = 1'b0;
    tx_req = 1'b1;
    tick();
    tick();
    tx_req = 1'b0;
    check("pops_per_line", 32'(rd_ptr - p0), 32'(LW));
    check("byte_num_hold", 32'(tx_byte_num), exp_bytes);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input bit seq);
    int s0, r0, b0, n;
    bit seen;
    transfer_flag = v.flag;
    push_words(V * LW, seq);
    s0 = starts;
    r0 = rd_ptr;
    b0 = busy_cycles;
    n  = 0;
    pulse_vsync();
    for (int l = 0; l < V; l++) begin
      wait_start(40, seen);
      if (!seen) break;
      run_packet(l == 0, v.gap, v.mid_vsync && l == 1);
      n++;
      if (v.drop && l == 0) transfer_flag = 1'b0;
    end
    repeat (20) tick();
    check("packets", 32'(n), 32'(v.exp_pkts));
    check("start_pulses", 32'(starts - s0), 32'(v.exp_pkts));
    check("frame_pops", 32'(rd_ptr - r0), 32'(v.exp_pkts * LW));
    check("busy_seen", 32'(busy_cycles > b0), 32'(v.exp_pkts > 0));
    check("busy_end", 32'(frame_busy), 32'd0);
  endtask

  initial begin
    bit seen;
    int s0;

    vecs[0] = '{flag: 1'b1, drop: 1'b0, gap: 0, mid_vsync: 1'b0, exp_pkts: 3};
    vecs[1] = '{flag: 1'b0, drop: 1'b0, gap: 0, mid_vsync: 1'b0, exp_pkts: 0};
    vecs[2] = '{flag: 1'b1, drop: 1'b1, gap: 1, mid_vsync: 1'b0, exp_pkts: 3};
    vecs[3] = '{flag: 1'b0, drop: 1'b0, gap: 1, mid_vsync: 1'b0, exp_pkts: 0};
    vecs[4] = '{flag: 1'b1, drop: 1'b0, gap: 2, mid_vsync: 1'b1, exp_pkts: 3};

    rst           = 1'b1;
    transfer_flag = 1'b0;
    frame_vsync   = 1'b0;
    tx_req        = 1'b0;
    tx_done       = 1'b0;
    repeat (3) tick();
    check("rst_start_en", 32'(tx_start_en), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_byte_num", 32'(tx_byte_num), 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_busy", 32'(frame_busy), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) run_frame(vecs[i], i == 0);

    // FIFO below one line: the block must hold off until a full line is present.
    transfer_flag = 1'b1;
    push_words(V * LW, 1'b0);
    cnt_force = 1'b1;
    cnt_val   = 12'd3;
    s0        = starts;
    pulse_vsync();
    repeat (20) tick();
    check("low_cnt_no_start", 32'(starts - s0), 32'd0);
    check("low_cnt_busy", 32'(frame_busy), 32'd1);
    cnt_val = 12'd4;
    wait_start(3, seen);
    check("start_within_2", 32'(seen), 32'd1);
    cnt_force = 1'b0;
    if (seen) run_packet(1'b1, 0, 1'b0);
    for (int l = 1; l < V; l++) begin
      wait_start(40, seen);
      check("low_cnt_line_start", 32'(seen), 32'd1);
      if (seen) run_packet(1'b0, 2, 1'b0);
    end
    repeat (5) tick();
    check("low_cnt_busy_end", 32'(frame_busy), 32'd0);

    // Reset in the middle of line 1, then a fresh frame from line 0.
    push_words(V * LW, 1'b0);
    pulse_vsync();
    wait_start(40, seen);
    if (seen) run_packet(1'b1, 0, 1'b0);
    wait_start(40, seen);
    check("l1_start", 32'(seen), 32'd1);
    tick();
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    check("l1_word0", tx_data, fmem[m_rd % 256]);
    m_rd++;
    rst = 1'b1;
    tick();
    check("mid_rst_start_en", 32'(tx_start_en), 32'd0);
    check("mid_rst_byte_num", 32'(tx_byte_num), 32'd0);
    check("mid_rst_tx_data", tx_data, 32'd0);
    check("mid_rst_busy", 32'(frame_busy), 32'd0);
    tx_req = 1'b1;
    #1;
    check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    tx_req = 1'b0;
    rst    = 1'b0;
    tick();
    run_frame(vecs[0], 1'b0);

    check("no_underflow_pops", 32'(bad_pops), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/img_udp_pkt_tx.md
Name: img_udp_pkt_tx

Overview:
- Downstream of the transfer-control stage.
- Consumes transfer_flag and packetises camera frames for the UDP transmitter: one UDP packet per image line, read from the pixel FIFO (already in the Ethernet clock domain).
- The first packet of each frame is prefixed with a 32-bit frame header word.
- Gating by transfer_flag takes effect only at frame boundaries, so a stop request never truncates a frame.

Parameters:
- H_PIXEL, 640, pixels per line (16-bit RGB565, even); one line = H_PIXEL/2 words.
- V_PIXEL, 480, lines per frame.
- FRAME_HEAD, 32'hF0_5A_A5_0F, header word sent first in line 0's packet.

Ports:
- clk  in  1  Ethernet user clock.
- rst  in  1  reset, synchronous, active-high.
- transfer_flag  in  1  1 = streaming enabled.
- frame_vsync  in  1  frame sync level, already synchronised to clk; rising edge = new frame.
- fifo_rd_cnt  in  12  words available in the pixel FIFO.
- fifo_rd_data  in  32  FIFO word, valid the cycle after fifo_rd_en; two pixels, first pixel in [31:16].
- fifo_rd_en  out  1  FIFO pop.
- tx_req  in  1  UDP transmitter requests the next word; data is expected on tx_data the following cycle.
- tx_done  in  1  one-cycle pulse when the UDP packet is fully sent.
- tx_start_en  out  1  one-cycle packet start pulse.
- tx_byte_num  out  16  payload byte count, held stable from tx_start_en until tx_done.
- tx_data  out  32  payload word.
- frame_busy  out  1  high from frame accept until the last line's tx_done.

Behaviour:
- Reset: all outputs 0; state = WAIT_FRAME; line_cnt = 0; hdr_pend = 0.
- vsync_rise = frame_vsync & ~frame_vsync_d1 (registered).
- WAIT_FRAME:
  - on vsync_rise & transfer_flag: line_cnt <= 0, hdr_pend <= 1, frame_busy <= 1, go to WAIT_LINE.
  - vsync_rise with transfer_flag = 0 is ignored.
- WAIT_LINE:
  - when fifo_rd_cnt >= H_PIXEL/2, go to START.
  - a vsync_rise seen here is ignored, with no resync; the frame must finish.
- START (one cycle):
  - tx_start_en = 1.
  - tx_byte_num = H_PIXEL*2 + (hdr_pend ? 4 : 0); 1280 or 1284 at default parameters.
  - go to SEND.
- SEND, per tx_req cycle n:
  - if hdr_pend: tx_data <= FRAME_HEAD at n+1; hdr_pend <= 0; no FIFO pop.
  - else: fifo_rd_en = 1 combinationally in cycle n; tx_data = fifo_rd_data in n+1 (registered select flag chooses the FIFO path).
  - word_cnt counts pops; after the H_PIXEL/2-th pop, go to WAIT_DONE.
  - tx_req asserted in WAIT_DONE does not pop.
- WAIT_DONE:
  - on tx_done: if line_cnt == V_PIXEL-1, frame_busy <= 0 and go to WAIT_FRAME; else line_cnt++ and go to WAIT_LINE.
- transfer_flag falling mid-frame: no effect until the frame ends, then no new frame is accepted.
- transfer_flag rising mid-frame (including during WAIT_FRAME): the next vsync_rise is accepted.
- tx_done outside WAIT_DONE is ignored.
- Pop count never exceeds H_PIXEL/2 per line; the block never pops when fifo_rd_cnt is 0.
- rst mid-packet: immediate return to reset state. The FIFO is not flushed here; flushing is the top level's responsibility.
- Counters: line_cnt 10 bits, word_cnt 10 bits. No wrap beyond V_PIXEL-1 or H_PIXEL/2-1.

Decomposition:
- Shared package holds:
  - FSM state encoding: WAIT_FRAME, WAIT_LINE, START, SEND, WAIT_DONE.
  - default FRAME_HEAD.
  - HDR_BYTES = 4.
- Optional sub-module vsync_edge_det (two-flop edge detector, reusable by other video blocks).
- Everything else stays in one module.

Test Plan:
- Bench parameters for scenarios 1–5: H_PIXEL=8, V_PIXEL=3.
1. transfer_flag=1, vsync pulse, FIFO preloaded with 12 words 0x0001_0002.. → exactly 3 tx_start_en pulses; tx_byte_num 20, 16, 16; first packet data = F05AA50F then 4 FIFO words in order; frame_busy falls after the 3rd tx_done.
2. transfer_flag=0 at vsync → no tx_start_en, no fifo_rd_en for the whole frame; frame_busy stays 0.
3. transfer_flag drops after packet 1 → packets 2 and 3 still sent; the next vsync is ignored.
4. fifo_rd_cnt held at 3 (< 4) → block waits in WAIT_LINE with no start pulse. Raise it to 4 → tx_start_en fires within 2 cycles.
5. tx_req every other cycle plus spurious tx_req in WAIT_DONE → pops exactly 4 per line; tx_data always the word popped in the previous request cycle.
6. rst asserted during SEND of line 1 → all outputs 0 next cycle. A new vsync with transfer_flag=1 then restarts at line 0, with the header.
